// File: rtl/ixc_osf_pkg.sv
// ----------------------------------------------------------------------------
// ixc_osf_pkg
// Shared types and constants for the OSF event scheduler.
//   state_t      : scheduler FSM states
//   DEF_*        : default requester count / FIFO depth and derived widths
//   rr_wrap_inc  : round-robin pointer increment with wrap at nreq
// ----------------------------------------------------------------------------
package ixc_osf_pkg;

    localparam int DEF_NREQ  = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_IDW   = $clog2(DEF_NREQ);
    localparam int DEF_CRW   = $clog2(DEF_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_STALL,
        S_DONE
    } state_t;

    // Next round-robin start position after granting 'ptr'.
    function automatic int rr_wrap_inc(input int ptr, input int nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ixc_osf_evsched_if.sv
// ----------------------------------------------------------------------------
// ixc_osf_evsched_if
// OSF transaction channel between the event scheduler (master) and the
// OSF GFIFO write side (slave).
//   osf_valid      : write request (master -> slave)
//   osf_id         : requester id carried with osf_valid (master -> slave)
//   osf_tbc        : transaction-to-be-called flag (master -> slave)
//   osf_ready      : FIFO accepts the write this cycle (slave -> master)
//   osf_credit_ret : one FIFO entry freed this cycle (slave -> master)
// ----------------------------------------------------------------------------
interface ixc_osf_evsched_if
    import ixc_osf_pkg::*;
#(
    parameter int IDW = DEF_IDW
);
    logic           osf_valid;
    logic [IDW-1:0] osf_id;
    logic           osf_tbc;
    logic           osf_ready;
    logic           osf_credit_ret;

    modport master (
        output osf_valid,
        output osf_id,
        output osf_tbc,
        input  osf_ready,
        input  osf_credit_ret
    );

    modport slave (
        input  osf_valid,
        input  osf_id,
        input  osf_tbc,
        output osf_ready,
        output osf_credit_ret
    );
endinterface

// File: rtl/ixc_osf_rr_pick.sv
// ----------------------------------------------------------------------------
// ixc_osf_rr_pick
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo NREQ.
//   req    : request vector
//   ptr    : start position
//   gnt_id : chosen requester (valid when any=1)
//   any    : at least one request set
// ----------------------------------------------------------------------------
module ixc_osf_rr_pick #(
    parameter int NREQ = 8,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);
    // Upper copy of req supplies the wrapped-around candidates; only the
    // lower copy is masked below ptr, so the lowest set bit of the masked
    // double vector is the round-robin winner.
    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_masked;

    assign w_dbl = {req, req};

    for (genvar gi = 0; gi < 2 * NREQ; gi++) begin : g_mask
        assign w_masked[gi] = w_dbl[gi] & (gi >= int'(ptr));
    end

    always_comb begin
        gnt_id = '0;
        for (int k = 2 * NREQ - 1; k >= 0; k--) begin
            if (w_masked[k]) begin
                gnt_id = (k >= NREQ) ? IDW'(k - NREQ) : IDW'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ixc_osf_evsched.sv
// ----------------------------------------------------------------------------
// ixc_osf_evsched
// Shares the OSF transaction channel between NREQ event requesters. Rising
// edges on ev_in become pending bits, which are granted round-robin onto the
// OSF FIFO write port, one per handshake, throttled by a FIFO credit count.
// When the pending set drains, emu_call_pre pulses for one cycle.
//   uclk         : user clock
//   rst          : asynchronous active-high reset
//   ev_in        : per-requester event level (rising edge = event)
//   osf          : OSF channel (master side)
//   emu_call_pre : one-cycle pulse when the batch has drained
//   ev_pend      : registered pending bits
//   ev_ovf       : sticky, event merged into an already-pending bit
//   credit_err   : sticky, credit returned while credits were full
// ----------------------------------------------------------------------------
module ixc_osf_evsched
    import ixc_osf_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDW   = $clog2(NREQ),
    parameter int CRW   = $clog2(DEPTH + 1)
) (
    input  logic              uclk,
    input  logic              rst,
    input  logic [NREQ-1:0]   ev_in,
    ixc_osf_evsched_if.master osf,
    output logic              emu_call_pre,
    output logic [NREQ-1:0]   ev_pend,
    output logic              ev_ovf,
    output logic              credit_err
);
    state_t          r_state;
    state_t          w_state_next;
    logic            r_armed;
    logic [NREQ-1:0] r_hist;
    logic [NREQ-1:0] r_pend;
    logic [CRW-1:0]  r_credits;
    logic [IDW-1:0]  r_rr_ptr;
    logic            r_valid;
    logic [IDW-1:0]  r_id;
    logic            r_tbc;
    logic            r_call_pre;
    logic            r_ovf;
    logic            r_cerr;

    logic [NREQ-1:0] w_evt;
    logic [NREQ-1:0] w_clr;
    logic [NREQ-1:0] w_pend_next;
    logic            w_hs;
    logic            w_merge;
    logic [CRW-1:0]  w_credits_next;
    logic            w_cerr_set;
    logic [IDW-1:0]  w_pick_id;
    logic            w_pick_any;

    // The first edge after reset only loads the history, so a level held
    // high through reset is not mistaken for a new event.
    assign w_evt = r_armed ? (ev_in & ~r_hist) : '0;
    assign w_hs  = r_valid & osf.osf_ready;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_clr
        assign w_clr[gi] = w_hs && (r_id == IDW'(gi));
    end

    // Set wins over a same-cycle clear of the same bit.
    assign w_pend_next = (r_pend & ~w_clr) | w_evt;
    assign w_merge     = |(w_evt & r_pend & ~w_clr);

    always_comb begin
        w_credits_next = r_credits;
        w_cerr_set     = 1'b0;
        if (w_hs && !osf.osf_credit_ret) begin
            w_credits_next = r_credits - CRW'(1);
        end else if (!w_hs && osf.osf_credit_ret) begin
            if (r_credits == CRW'(DEPTH)) begin
                w_cerr_set = 1'b1;
            end else begin
                w_credits_next = r_credits + CRW'(1);
            end
        end
    end

    ixc_osf_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (r_pend),
        .ptr    (r_rr_ptr),
        .gnt_id (w_pick_id),
        .any    (w_pick_any)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((|r_pend) && (r_credits != '0)) w_state_next = S_ARB;
            end
            S_ARB: begin
                w_state_next = w_pick_any ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                if (w_hs) begin
                    if (|w_pend_next) begin
                        w_state_next = (w_credits_next != '0) ? S_ARB : S_STALL;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_STALL: begin
                if (r_credits != '0) w_state_next = S_ARB;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Channel outputs are decoded from the next state so they leave flops.
    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_hist     <= '0;
            r_pend     <= '0;
            r_credits  <= CRW'(DEPTH);
            r_rr_ptr   <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_tbc      <= 1'b0;
            r_call_pre <= 1'b0;
            r_ovf      <= 1'b0;
            r_cerr     <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_hist     <= ev_in;
            r_pend     <= w_pend_next;
            r_tbc      <= |w_pend_next;
            r_credits  <= w_credits_next;
            r_valid    <= (w_state_next == S_SEND);
            r_call_pre <= (w_state_next == S_DONE);
            if (w_hs) r_rr_ptr <= IDW'(rr_wrap_inc(int'(r_id), NREQ));
            if (r_state == S_ARB) r_id <= w_pick_id;
            if (w_merge) r_ovf <= 1'b1;
            if (w_cerr_set) r_cerr <= 1'b1;
        end
    end

    assign osf.osf_valid = r_valid;
    assign osf.osf_id    = r_id;
    assign osf.osf_tbc   = r_tbc;
    assign emu_call_pre  = r_call_pre;
    assign ev_pend       = r_pend;
    assign ev_ovf        = r_ovf;
    assign credit_err    = r_cerr;

endmodule

// File: tb/tb_ixc_osf_evsched.sv
// ----------------------------------------------------------------------------
// tb_ixc_osf_evsched
// Directed scenarios plus a random phase for ixc_osf_evsched. A small
// transaction-level model (pending set, credit count, sticky flags) is
// advanced once per clock from the driven inputs and observed handshakes.
// ----------------------------------------------------------------------------
module tb_ixc_osf_evsched;
    import ixc_osf_pkg::*;

    localparam int NREQ  = DEF_NREQ;
    localparam int DEPTH = DEF_DEPTH;
    localparam int IDW   = DEF_IDW;

    logic            uclk = 1'b0;
    logic            rst  = 1'b0;
    logic [NREQ-1:0] ev_in = '0;
    logic            emu_call_pre;
    logic [NREQ-1:0] ev_pend;
    logic            ev_ovf;
    logic            credit_err;

    ixc_osf_evsched_if #(.IDW(IDW)) osf ();

    ixc_osf_evsched #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .uclk         (uclk),
        .rst          (rst),
        .ev_in        (ev_in),
        .osf          (osf),
        .emu_call_pre (emu_call_pre),
        .ev_pend      (ev_pend),
        .ev_ovf       (ev_ovf),
        .credit_err   (credit_err)
    );

    always #5 uclk = ~uclk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [NREQ-1:0]    m_hist;
    logic [NREQ-1:0]    m_pend;
    logic               m_armed;
    logic [DEF_CRW-1:0] m_credits;
    logic               m_ovf;
    logic               m_cerr;
    logic               p_valid;
    logic [IDW-1:0]     p_id;
    logic               p_call;
    int                 q_grants[$];
    int                 n_call;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int get_grant(input int i);
        if (i < q_grants.size()) return q_grants[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_hist    = '0;
        m_pend    = '0;
        m_armed   = 1'b0;
        m_credits = DEF_CRW'(DEPTH);
        m_ovf     = 1'b0;
        m_cerr    = 1'b0;
        p_valid   = 1'b0;
        p_id      = '0;
        p_call    = 1'b0;
        q_grants.delete();
        n_call    = 0;
    endtask

    // One clock: advance the model from this cycle's inputs, then compare.
    task automatic tick();
        logic            hs;
        logic            ret;
        logic [NREQ-1:0] evt;
        logic [NREQ-1:0] clr;
        hs  = (osf.osf_valid === 1'b1) && (osf.osf_ready === 1'b1);
        ret = osf.osf_credit_ret;
        clr = '0;
        if (hs) begin
            chk("grant_was_pending", 32'(m_pend[osf.osf_id]), 32'd1);
            chk("grant_had_credit", 32'(m_credits != '0), 32'd1);
            clr[osf.osf_id] = 1'b1;
            q_grants.push_back(int'(osf.osf_id));
            $display("grant id=%0d t=%0t", osf.osf_id, $time);
        end
        evt = m_armed ? (ev_in & ~m_hist) : '0;
        if ((evt & m_pend & ~clr) != '0) m_ovf = 1'b1;
        m_pend  = (m_pend & ~clr) | evt;
        m_hist  = ev_in;
        m_armed = 1'b1;
        if (hs && !ret) begin
            m_credits = m_credits - 1'b1;
        end else if (!hs && ret) begin
            if (m_credits == DEF_CRW'(DEPTH)) m_cerr = 1'b1;
            else m_credits = m_credits + 1'b1;
        end
        p_valid = osf.osf_valid;
        p_id    = osf.osf_id;
        p_call  = emu_call_pre;
        @(posedge uclk);
        #1;
        chk("ev_pend", 32'(ev_pend), 32'(m_pend));
        chk("osf_tbc", 32'(osf.osf_tbc), 32'(|m_pend));
        chk("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
        chk("credit_err", 32'(credit_err), 32'(m_cerr));
        if (p_valid === 1'b1 && !hs) begin
            chk("valid_hold", 32'(osf.osf_valid), 32'd1);
            chk("id_hold", 32'(osf.osf_id), 32'(p_id));
        end
        if (emu_call_pre === 1'b1) begin
            n_call++;
            chk("drained_at_call", 32'(ev_pend), 32'd0);
        end
        if (p_call === 1'b1) chk("call_pre_one_cycle", 32'(emu_call_pre), 32'd0);
    endtask

    task automatic do_reset();
        ev_in              = '0;
        osf.osf_ready      = 1'b0;
        osf.osf_credit_ret = 1'b0;
        rst                = 1'b1;
        repeat (2) @(posedge uclk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (osf.osf_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(osf.osf_valid), 32'd1);
    endtask

    task automatic wait_grants(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (q_grants.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(q_grants.size()), 32'(cnt));
    endtask

    // Drain everything and refill the credits.
    task automatic settle();
        osf.osf_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            osf.osf_credit_ret = (m_credits != DEF_CRW'(DEPTH)) && (n > 2);
            tick();
        end
        osf.osf_credit_ret = 1'b0;
        chk("settle_credits", 32'(m_credits), 32'(DEPTH));
    endtask

    int exp_rr[4] = '{0, 2, 7, 0};

    initial begin
        osf.osf_ready      = 1'b0;
        osf.osf_credit_ret = 1'b0;
        model_reset();

        // reset state
        do_reset();
        chk("rst_valid", 32'(osf.osf_valid), 32'd0);
        chk("rst_tbc", 32'(osf.osf_tbc), 32'd0);
        chk("rst_pend", 32'(ev_pend), 32'd0);
        chk("rst_call", 32'(emu_call_pre), 32'd0);
        chk("rst_ovf", 32'(ev_ovf), 32'd0);
        chk("rst_cerr", 32'(credit_err), 32'd0);
        tick();

        // single event latency
        osf.osf_ready = 1'b1;
        ev_in = 8'h08;
        tick();
        chk("t1_pend", 32'(ev_pend), 32'h08);
        tick();
        chk("t1_arb_valid", 32'(osf.osf_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(osf.osf_valid), 32'd1);
        chk("t1_id", 32'(osf.osf_id), 32'd3);
        tick();
        chk("t1_pend_clr", 32'(ev_pend), 32'd0);
        chk("t1_call", 32'(emu_call_pre), 32'd1);
        chk("t1_tbc", 32'(osf.osf_tbc), 32'd0);
        chk("t1_grant", 32'(get_grant(0)), 32'd3);
        tick();
        chk("t1_call_end", 32'(emu_call_pre), 32'd0);
        settle();

        // round-robin fairness
        do_reset();
        tick();
        osf.osf_ready = 1'b1;
        ev_in = 8'h85;
        tick();
        ev_in = 8'h84;
        repeat (3) tick();
        ev_in = 8'h85;
        wait_grants("rr_count", 4, 20);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(get_grant(i)), 32'(exp_rr[i]));
        end
        chk("rr_calls", 32'(n_call), 32'd1);
        settle();

        // credit stall
        do_reset();
        tick();
        osf.osf_ready = 1'b1;
        ev_in = 8'h3F;
        repeat (20) tick();
        chk("cs_grants", 32'(q_grants.size()), 32'd4);
        chk("cs_pend", 32'(ev_pend), 32'h30);
        chk("cs_valid", 32'(osf.osf_valid), 32'd0);
        chk("cs_calls", 32'(n_call), 32'd0);
        osf.osf_credit_ret = 1'b1;
        tick();
        osf.osf_credit_ret = 1'b0;
        tick();
        tick();
        chk("cs_5th_valid", 32'(osf.osf_valid), 32'd1);
        chk("cs_5th_id", 32'(osf.osf_id), 32'd4);
        tick();
        osf.osf_credit_ret = 1'b1;
        tick();
        osf.osf_credit_ret = 1'b0;
        wait_grants("cs_6th", 6, 10);
        repeat (4) tick();
        chk("cs_calls_end", 32'(n_call), 32'd1);
        chk("cs_cerr", 32'(credit_err), 32'd0);
        settle();

        // backpressure
        do_reset();
        tick();
        ev_in = 8'h20;
        wait_valid("bp_valid", 10);
        repeat (5) tick();
        chk("bp_id", 32'(osf.osf_id), 32'd5);
        chk("bp_no_grant", 32'(q_grants.size()), 32'd0);
        osf.osf_ready = 1'b1;
        tick();
        chk("bp_grant", 32'(get_grant(0)), 32'd5);
        settle();

        // set and clear on the same bit in the same cycle
        do_reset();
        tick();
        ev_in = 8'h02;
        tick();
        ev_in = 8'h00;
        wait_valid("sc_valid", 10);
        chk("sc_id", 32'(osf.osf_id), 32'd1);
        osf.osf_ready = 1'b1;
        ev_in = 8'h02;
        tick();
        chk("sc_pend_kept", 32'(ev_pend), 32'h02);
        chk("sc_no_ovf", 32'(ev_ovf), 32'd0);
        wait_grants("sc_second", 2, 10);
        chk("sc_second_id", 32'(get_grant(1)), 32'd1);
        settle();

        // overflow merge
        do_reset();
        tick();
        ev_in = 8'h02;
        tick();
        ev_in = 8'h00;
        tick();
        ev_in = 8'h02;
        tick();
        chk("ovf_set", 32'(ev_ovf), 32'd1);
        ev_in = 8'h00;
        tick();
        ev_in = 8'h02;
        tick();
        osf.osf_ready = 1'b1;
        repeat (10) tick();
        chk("ovf_grants", 32'(q_grants.size()), 32'd1);
        chk("ovf_id", 32'(get_grant(0)), 32'd1);
        chk("ovf_sticky", 32'(ev_ovf), 32'd1);
        settle();

        // async reset in the middle of SEND
        do_reset();
        tick();
        osf.osf_ready = 1'b1;
        ev_in = 8'h10;
        wait_grants("ar_pre", 1, 10);
        repeat (3) tick();
        osf.osf_ready = 1'b0;
        ev_in = 8'h30;
        wait_valid("ar_send", 10);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid_now", 32'(osf.osf_valid), 32'd0);
        chk("ar_tbc_now", 32'(osf.osf_tbc), 32'd0);
        chk("ar_pend_now", 32'(ev_pend), 32'd0);
        @(posedge uclk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) tick();
        chk("ar_no_event", 32'(ev_pend), 32'd0);
        chk("ar_no_valid", 32'(osf.osf_valid), 32'd0);
        osf.osf_ready = 1'b1;
        ev_in = 8'hB1;
        wait_grants("ar_two", 2, 20);
        chk("ar_first", 32'(get_grant(0)), 32'd0);
        chk("ar_second", 32'(get_grant(1)), 32'd7);
        ev_in = 8'h30;
        tick();
        ev_in = 8'h3E;
        repeat (15) tick();
        chk("ar_credit_full", 32'(q_grants.size()), 32'd4);
        chk("ar_stall_pend", 32'(ev_pend), 32'h08);
        settle();

        // random traffic
        do_reset();
        tick();
        for (int c = 0; c < 500; c++) begin
            logic [NREQ-1:0] flip;
            for (int b = 0; b < NREQ; b++) flip[b] = ($urandom_range(7) == 0);
            ev_in = ev_in ^ flip;
            osf.osf_ready = ($urandom_range(3) != 0);
            osf.osf_credit_ret = (m_credits != DEF_CRW'(DEPTH)) && ($urandom_range(2) == 0);
            tick();
        end
        ev_in = '0;
        settle();
        chk("rnd_drained", 32'(ev_pend), 32'd0);
        chk("rnd_called", 32'(n_call > 0), 32'd1);

        // credit returned while full
        osf.osf_credit_ret = 1'b1;
        tick();
        osf.osf_credit_ret = 1'b0;
        chk("cerr_set", 32'(credit_err), 32'd1);
        tick();
        chk("cerr_sticky", 32'(credit_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
